oled_write_queue: RTL and testbench
===================================

# oled_write_queue

Write-buffering sequencer between the CPU bus and the SSD1351 SPI interface. It accepts display writes (control, command, 8-bit data, 16-bit data) into a FIFO, so the CPU need not poll the serializer's busy flag. It drains the FIFO one entry at a time into the SPI interface's strobe/select port, respecting that block's `wbusy`. An optional fill command repeats one 16-bit pixel N times.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, 2..256.
- `AW`, 4: log2(`DEPTH`).
- `clk` in 1: system clock; everything is on its rising edge.
- `reset` in 1: synchronous, active-high.
- `wstrb` in 1: CPU write strobe.
- `sel_cntl` in 1: queue control word; wdata[0]=!CS, wdata[1]=RST.
- `sel_cmd` in 1: queue 8-bit command, wdata[7:0].
- `sel_dat` in 1: queue 8-bit data, wdata[7:0].
- `sel_dat16` in 1: queue 16-bit data, wdata[15:0].
- `sel_fill` in 1: queue fill; colour is wdata[15:0], count is wdata[31:16]. Ignored unless `OLED_FILL_EN`.
- `wdata` in 32: CPU write data.
- `wbusy` out 1: FIFO full.
- `level` out AW+1: number of FIFO entries.
- `idle` out 1: FIFO empty, sequencer in IDLE, and `spi_wbusy` low.
- `overflow` out 1: sticky; set when a write is dropped while full.
- `spi_wstrb`, `spi_sel_cntl`, `spi_sel_cmd`, `spi_sel_dat`, `spi_sel_dat16` out 1: downstream strobe and selects.
- `spi_wdata` out 32: downstream write data.
- `spi_wbusy` in 1: downstream busy.

## Operation
- Entry format: 3-bit type {CNTL, CMD, DAT, DAT16, FILL} plus 32-bit data. Circular buffer with read/write pointers of AW bits that wrap modulo DEPTH. `level` is a separate registered count.
- Push: `wstrb` and at least one valid select and not full. If several selects are set, exactly one entry is pushed, chosen by priority cntl > cmd > dat > dat16 > fill. `wstrb` with no valid select is ignored and does not set `overflow`.
- Full: push is dropped and `overflow` is set. Full is evaluated before any same-cycle pop, so a push while full is dropped even if a pop occurs that cycle.
- Simultaneous push and pop when not full: both happen; `level` is unchanged.
- Sequencer FSM:
  - IDLE: if not empty, pop the head into the output registers and go to ISSUE. A FILL with count 0 is popped and discarded; the FSM stays in IDLE.
  - ISSUE: `spi_wstrb`=1 with exactly one select, for one cycle. For FILL, issue `spi_sel_dat16` with the colour and decrement the remaining count. Go to SETTLE.
  - SETTLE: one cycle with no action; this covers the downstream busy flag registering one cycle after the strobe. Go to WAIT.
  - WAIT: while `spi_wbusy`=1, stay. When it is 0: go to ISSUE if fill remaining ≠ 0, otherwise IDLE.
- CNTL entries do not make downstream busy, so they pass through WAIT in one cycle.
- Order of entries is preserved exactly.
- Outputs are registered. When not in ISSUE, `spi_wstrb` and all `spi_sel_*` are 0; `spi_wdata` holds its last value.

## Timing
- Reset values: `spi_wstrb`=0, all `spi_sel_*`=0, `spi_wdata`=0, `wbusy`=0, `level`=0, `overflow`=0, `idle`=1, FSM in IDLE, pointers 0.
- Reset mid-operation flushes the FIFO and aborts any fill. A transfer already in flight downstream completes on its own.
- Push in cycle t into an empty FIFO with FSM in IDLE: `level`=1 at t+1, pop at t+1, `spi_wstrb` at t+2.
- Minimum spacing between strobes is 3 cycles (ISSUE, SETTLE, WAIT).
- `wbusy` rises the cycle after the push that fills the FIFO. It falls the cycle after a pop.

## Configuration
- `OLED_FILL_EN` defined: the FILL type, the `sel_fill` decode and the 16-bit remaining-count register are compiled in.
- `OLED_FILL_EN` undefined: `sel_fill` is ignored (no push, no overflow), the type field encodes four values, and no counter is built.

## Test plan
- Reset, then push CMD 0xAF: `spi_wstrb` pulses exactly 2 cycles after the push, with `spi_sel_cmd`=1 and `spi_wdata[7:0]`=0xAF. `idle` returns to 1 after the downstream model clears busy.
- Push CNTL 0x3, DAT 0x12, DAT16 0xF800 back-to-back: three strobes in that order with the matching selects. Each strobe after the first waits for `spi_wbusy` low plus the SETTLE cycle.
- Stall downstream busy and push DEPTH+2 entries: `wbusy`=1 after DEPTH pushes, `level`=DEPTH, `overflow`=1, and the two extra entries never appear downstream.
- With `OLED_FILL_EN`, push FILL count 3 colour 0x07E0: three DAT16 strobes of 0x07E0. FILL count 0: no strobe, and `level` returns to 0.
- Assert `reset` during a fill with 5 entries queued: the next cycle has `level`=0, `spi_wstrb`=0, `overflow`=0, and no further strobes occur.
- Push with `sel_cmd` and `sel_dat` set together: a single CMD entry; `level` increments by 1.

Source files
------------

// File: rtl/oled_write_queue.sv
// Write-buffering FIFO and strobe sequencer in front of the SSD1351 SPI serializer.
// Define OLED_FILL_EN to build the FILL entry type (one 16-bit pixel repeated N times).
module oled_write_queue #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_wstrb,
  input  logic          i_sel_cntl,
  input  logic          i_sel_cmd,
  input  logic          i_sel_dat,
  input  logic          i_sel_dat16,
  input  logic          i_sel_fill,
  input  logic [31:0]   i_wdata,
  output logic          o_wbusy,
  output logic [AW:0]   o_level,
  output logic          o_idle,
  output logic          o_overflow,
  output logic          o_spi_wstrb,
  output logic          o_spi_sel_cntl,
  output logic          o_spi_sel_cmd,
  output logic          o_spi_sel_dat,
  output logic          o_spi_sel_dat16,
  output logic [31:0]   o_spi_wdata,
  input  logic          i_spi_wbusy
);

`ifdef OLED_FILL_EN
  localparam int unsigned TW = 3;
`else
  localparam int unsigned TW = 2;
`endif

  localparam logic [TW-1:0] TyCntl  = TW'(0);
  localparam logic [TW-1:0] TyCmd   = TW'(1);
  localparam logic [TW-1:0] TyDat   = TW'(2);
  localparam logic [TW-1:0] TyDat16 = TW'(3);
`ifdef OLED_FILL_EN
  localparam logic [TW-1:0] TyFill  = TW'(4);
`endif

  typedef enum logic [1:0] {StIdle, StIssue, StSettle, StWait} state_e;

  logic [TW-1:0] r_mem_type [DEPTH];
  logic [31:0]   r_mem_data [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_level;
  logic          r_overflow;
  state_e        r_state;
  state_e        w_state_d;
  logic [TW-1:0] r_cur_type;

  logic          r_spi_wstrb;
  logic          r_spi_sel_cntl;
  logic          r_spi_sel_cmd;
  logic          r_spi_sel_dat;
  logic          r_spi_sel_dat16;
  logic [31:0]   r_spi_wdata;

  logic          w_any_sel;
  logic [TW-1:0] w_push_type;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic [TW-1:0] w_head_type;
  logic [31:0]   w_head_data;
  logic          w_head_is_fill;
  logic          w_head_fill_zero;
  logic          w_fill_more;
  logic [TW-1:0] w_iss_type;

  // Select priority: cntl > cmd > dat > dat16 > fill.
  always_comb begin
    w_any_sel   = 1'b1;
    w_push_type = TyCntl;
    if (i_sel_cntl) begin
      w_push_type = TyCntl;
    end else if (i_sel_cmd) begin
      w_push_type = TyCmd;
    end else if (i_sel_dat) begin
      w_push_type = TyDat;
    end else if (i_sel_dat16) begin
      w_push_type = TyDat16;
`ifdef OLED_FILL_EN
    end else if (i_sel_fill) begin
      w_push_type = TyFill;
`endif
    end else begin
      w_any_sel = 1'b0;
    end
  end

`ifndef OLED_FILL_EN
  logic w_unused_sel_fill;
  assign w_unused_sel_fill = i_sel_fill;
`endif

  // Full is judged on the registered level, so a same-cycle pop never rescues a push.
  assign w_full      = (r_level == (AW+1)'(DEPTH));
  assign w_push      = i_wstrb & w_any_sel & ~w_full;
  assign w_head_type = r_mem_type[r_rptr];
  assign w_head_data = r_mem_data[r_rptr];

`ifdef OLED_FILL_EN
  logic [15:0] r_fill_rem;
  assign w_head_is_fill   = (w_head_type == TyFill);
  assign w_head_fill_zero = w_head_is_fill & (w_head_data[31:16] == 16'h0);
  assign w_fill_more      = (r_fill_rem != 16'h0);
`else
  assign w_head_is_fill   = 1'b0;
  assign w_head_fill_zero = 1'b0;
  assign w_fill_more      = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem_type[r_wptr] <= w_push_type;
      r_mem_data[r_wptr] <= i_wdata;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      if (i_wstrb && w_any_sel && w_full) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= StIdle;
    else         r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    w_pop     = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (r_level != '0) begin
          w_pop = 1'b1;
          // Zero-count fills are consumed without touching the serializer.
          if (!w_head_fill_zero) w_state_d = StIssue;
        end
      end
      StIssue:  w_state_d = StSettle;
      StSettle: w_state_d = StWait;
      StWait: begin
        if (!i_spi_wbusy) w_state_d = w_fill_more ? StIssue : StIdle;
      end
      default:  w_state_d = StIdle;
    endcase
  end

  assign w_iss_type = (r_state == StIdle) ? w_head_type : r_cur_type;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_spi_wstrb     <= 1'b0;
      r_spi_sel_cntl  <= 1'b0;
      r_spi_sel_cmd   <= 1'b0;
      r_spi_sel_dat   <= 1'b0;
      r_spi_sel_dat16 <= 1'b0;
      r_spi_wdata     <= '0;
      r_cur_type      <= TyCntl;
    end else begin
      r_spi_wstrb     <= (w_state_d == StIssue);
      r_spi_sel_cntl  <= 1'b0;
      r_spi_sel_cmd   <= 1'b0;
      r_spi_sel_dat   <= 1'b0;
      r_spi_sel_dat16 <= 1'b0;
      if (w_state_d == StIssue) begin
        case (w_iss_type)
          TyCntl:  r_spi_sel_cntl  <= 1'b1;
          TyCmd:   r_spi_sel_cmd   <= 1'b1;
          TyDat:   r_spi_sel_dat   <= 1'b1;
          default: r_spi_sel_dat16 <= 1'b1;
        endcase
      end
      if (w_pop && (w_state_d == StIssue)) begin
        r_cur_type  <= w_head_type;
        r_spi_wdata <= w_head_is_fill ? {16'h0, w_head_data[15:0]} : w_head_data;
      end
    end
  end

`ifdef OLED_FILL_EN
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_fill_rem <= 16'h0;
    end else if (w_pop && w_head_is_fill) begin
      r_fill_rem <= w_head_data[31:16];
    end else if ((r_state == StIssue) && w_fill_more) begin
      r_fill_rem <= r_fill_rem - 16'h1;
    end
  end
`endif

  assign o_wbusy         = w_full;
  assign o_level         = r_level;
  assign o_idle          = (r_level == '0) & (r_state == StIdle) & ~i_spi_wbusy;
  assign o_overflow      = r_overflow;
  assign o_spi_wstrb     = r_spi_wstrb;
  assign o_spi_sel_cntl  = r_spi_sel_cntl;
  assign o_spi_sel_cmd   = r_spi_sel_cmd;
  assign o_spi_sel_dat   = r_spi_sel_dat;
  assign o_spi_sel_dat16 = r_spi_sel_dat16;
  assign o_spi_wdata     = r_spi_wdata;

endmodule

// File: tb/tb_oled_write_queue.sv
// Directed bench for oled_write_queue with a small busy-flag model of the SPI serializer.
module tb_oled_write_queue;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;

  localparam logic [4:0] S_CNTL  = 5'b00001;
  localparam logic [4:0] S_CMD   = 5'b00010;
  localparam logic [4:0] S_DAT   = 5'b00100;
  localparam logic [4:0] S_DAT16 = 5'b01000;
  localparam logic [4:0] S_FILL  = 5'b10000;

  logic        clk;
  logic        reset;
  logic        wstrb;
  logic [4:0]  sel;
  logic [31:0] wdata;
  logic        wbusy;
  logic [AW:0] level;
  logic        idle;
  logic        overflow;
  logic        spi_wstrb;
  logic        spi_sel_cntl;
  logic        spi_sel_cmd;
  logic        spi_sel_dat;
  logic        spi_sel_dat16;
  logic [31:0] spi_wdata;
  logic        spi_wbusy;
  logic        stall;
  int          busy_cnt;
  int          cyc;
  int          n_checks;
  int          n_errors;

  typedef struct {
    logic [4:0]  sel;
    logic [31:0] data;
    int          cyc;
  } strobe_t;
  strobe_t log_q[$];

  oled_write_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_wstrb        (wstrb),
    .i_sel_cntl     (sel[0]),
    .i_sel_cmd      (sel[1]),
    .i_sel_dat      (sel[2]),
    .i_sel_dat16    (sel[3]),
    .i_sel_fill     (sel[4]),
    .i_wdata        (wdata),
    .o_wbusy        (wbusy),
    .o_level        (level),
    .o_idle         (idle),
    .o_overflow     (overflow),
    .o_spi_wstrb    (spi_wstrb),
    .o_spi_sel_cntl (spi_sel_cntl),
    .o_spi_sel_cmd  (spi_sel_cmd),
    .o_spi_sel_dat  (spi_sel_dat),
    .o_spi_sel_dat16(spi_sel_dat16),
    .o_spi_wdata    (spi_wdata),
    .i_spi_wbusy    (spi_wbusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Serializer model: busy for three cycles starting the cycle after a non-control strobe.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (spi_wstrb && !spi_sel_cntl) busy_cnt <= 3;
    else if (busy_cnt != 0)         busy_cnt <= busy_cnt - 1;
  end
  assign spi_wbusy = stall | (busy_cnt != 0);

  always @(negedge clk) begin
    if (spi_wstrb)
      log_q.push_back('{sel: {1'b0, spi_sel_dat16, spi_sel_dat, spi_sel_cmd, spi_sel_cntl},
                        data: spi_wdata, cyc: cyc});
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Called at a negedge; the push is sampled at the following posedge.
  task automatic drive(input logic [4:0] s, input logic [31:0] d);
    wstrb = 1'b1;
    sel   = s;
    wdata = d;
    @(negedge clk);
    wstrb = 1'b0;
    sel   = '0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (!idle && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, idle, 1'b1);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    busy_cnt = 0;
    cyc      = 0;
    stall    = 1'b0;
    wstrb    = 1'b0;
    sel      = '0;
    wdata    = '0;
    reset    = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    check("rst_level", level, 0);
    check("rst_wbusy", wbusy, 0);
    check("rst_idle", idle, 1);
    check("rst_overflow", overflow, 0);
    check("rst_strobe", spi_wstrb, 0);
    check("rst_sels", {spi_sel_dat16, spi_sel_dat, spi_sel_cmd, spi_sel_cntl}, 0);
    check("rst_wdata", spi_wdata, 0);

    // Single command: level at t+1, strobe at t+2.
    drive(S_CMD, 32'h0000_00AF);
    check("cmd_level_t1", level, 1);
    check("cmd_strobe_t1", spi_wstrb, 0);
    @(negedge clk);
    check("cmd_strobe_t2", spi_wstrb, 1);
    check("cmd_sel_t2", spi_sel_cmd, 1);
    check("cmd_data_t2", spi_wdata[7:0], 8'hAF);
    @(negedge clk);
    check("cmd_strobe_t3", spi_wstrb, 0);
    check("cmd_data_hold", spi_wdata[7:0], 8'hAF);
    wait_idle("cmd_idle", 100);
    check("cmd_count", log_q.size(), 1);
    log_q.delete();

    // Back-to-back control, data, data16.
    drive(S_CNTL, 32'h0000_0003);
    drive(S_DAT, 32'h0000_0012);
    drive(S_DAT16, 32'h0000_F800);
    wait_idle("seq_idle", 200);
    check("seq_count", log_q.size(), 3);
    if (log_q.size() >= 3) begin
      check("seq0_sel", log_q[0].sel, S_CNTL);
      check("seq0_data", log_q[0].data, 32'h3);
      check("seq1_sel", log_q[1].sel, S_DAT);
      check("seq1_data", log_q[1].data, 32'h12);
      check("seq2_sel", log_q[2].sel, S_DAT16);
      check("seq2_data", log_q[2].data, 32'hF800);
      check("seq_gap01", log_q[1].cyc - log_q[0].cyc, 4);
      check("seq_gap12", log_q[2].cyc - log_q[1].cyc, 6);
    end
    log_q.delete();

    // Two selects at once: only the higher-priority command is queued.
    drive(S_CMD | S_DAT, 32'h0000_003C);
    check("multi_level", level, 1);
    wait_idle("multi_idle", 100);
    check("multi_count", log_q.size(), 1);
    if (log_q.size() >= 1) check("multi_sel", log_q[0].sel, S_CMD);
    log_q.delete();

    // Overflow: park the sequencer in WAIT, then overfill the FIFO.
    stall = 1'b1;
    drive(S_DAT, 32'h0000_0055);
    repeat (5) @(negedge clk);
    check("ovf_level0", level, 0);
    for (int i = 0; i < DEPTH + 2; i++) begin
      drive(S_DAT, 32'h100 + i);
      if (i == DEPTH - 2) check("ovf_wbusy_lo", wbusy, 0);
      if (i == DEPTH - 2) check("ovf_no_flag", overflow, 0);
      if (i == DEPTH - 1) check("ovf_wbusy_hi", wbusy, 1);
    end
    check("ovf_level", level, DEPTH);
    check("ovf_flag", overflow, 1);
    stall = 1'b0;
    wait_idle("ovf_idle", 3000);
    check("ovf_count", log_q.size(), DEPTH + 1);
    if (log_q.size() >= 1) check("ovf_first", log_q[0].data, 32'h55);
    for (int k = 0; k < DEPTH && k + 1 < log_q.size(); k++)
      check("ovf_order", log_q[k + 1].data, 32'h100 + k);
    check("ovf_wbusy_end", wbusy, 0);
    log_q.delete();

    // Reset while the sequencer is stuck with five entries behind it.
    stall = 1'b1;
`ifdef OLED_FILL_EN
    drive(S_FILL, {16'd100, 16'h1234});
`else
    drive(S_DAT, 32'h0000_0077);
`endif
    repeat (3) @(negedge clk);
    for (int i = 0; i < 5; i++) drive(S_DAT, 32'h200 + i);
    check("rst_mid_level", level, 5);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_level0", level, 0);
    check("rst_mid_strobe", spi_wstrb, 0);
    check("rst_mid_ovf", overflow, 0);
    reset = 1'b0;
    stall = 1'b0;
    log_q.delete();
    repeat (40) @(negedge clk);
    check("rst_mid_nostrobe", log_q.size(), 0);
    check("rst_mid_idle", idle, 1);
    log_q.delete();

`ifdef OLED_FILL_EN
    drive(S_FILL, {16'd3, 16'h07E0});
    wait_idle("fill_idle", 200);
    check("fill_count", log_q.size(), 3);
    for (int k = 0; k < 3 && k < log_q.size(); k++) begin
      check("fill_sel", log_q[k].sel, S_DAT16);
      check("fill_data", log_q[k].data, 32'h07E0);
    end
    log_q.delete();
    drive(S_FILL, {16'd0, 16'h07E0});
    check("fill0_level1", level, 1);
    @(negedge clk);
    check("fill0_level0", level, 0);
    repeat (10) @(negedge clk);
    check("fill0_nostrobe", log_q.size(), 0);
    check("fill0_idle", idle, 1);
`else
    drive(S_FILL, {16'd3, 16'h07E0});
    check("nofill_level", level, 0);
    repeat (10) @(negedge clk);
    check("nofill_nostrobe", log_q.size(), 0);
    check("nofill_ovf", overflow, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
